// File: rtl/sobel_frame_ctrl_if.sv
// Source-read, filter and destination-write signals between the frame
// sequencer (master) and the memories/filter around it (slave).
interface sobel_frame_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [7:0]        src_rd_data;
    logic              flt_rst;
    logic [7:0]        flt_pixel;
    logic              flt_valid;
    logic [7:0]        flt_out;
    logic              flt_out_valid;
    logic              dst_ready;
    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [7:0]        dst_wr_data;

    modport master (
        output src_rd_en, src_rd_addr, flt_rst, flt_pixel, flt_valid,
               dst_wr_en, dst_wr_addr, dst_wr_data,
        input  src_rd_data, flt_out, flt_out_valid, dst_ready
    );

    modport slave (
        input  src_rd_en, src_rd_addr, flt_rst, flt_pixel, flt_valid,
               dst_wr_en, dst_wr_addr, dst_wr_data,
        output src_rd_data, flt_out, flt_out_valid, dst_ready
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the streaming Sobel filter: resets the filter, streams
// one frame from source memory into it and writes the magnitudes to the
// destination through a 4-deep FIFO that absorbs destination back-pressure.
module sobel_frame_ctrl #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    sobel_frame_ctrl_if.master bus
);
    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_n;

    // vld_pipe[1]: read issued last cycle (pixel at filter now),
    // vld_pipe[2]: read issued two cycles ago (filter result visible now).
    logic [2:1]        vld_pipe;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [7:0]        fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_cnt, fifo_cnt_n, occ;
    logic              in_flow, kill, rd_issue, push, pop;

    assign in_flow = (state == S_RUN) || (state == S_DRAIN);
    assign kill    = abort && (state == S_INIT || in_flow);

    // Every issued read holds a FIFO slot until its result lands, so issuing
    // only while occupancy < 4 makes FIFO overflow impossible.
    assign occ        = fifo_cnt + {2'b0, vld_pipe[1]} + {2'b0, vld_pipe[2]};
    assign rd_issue   = (state == S_RUN) && !abort && (occ < 3'd4);
    assign push       = in_flow && vld_pipe[2] && bus.flt_out_valid;
    assign pop        = in_flow && !abort && bus.dst_ready && (fifo_cnt != 3'd0);
    assign fifo_cnt_n = fifo_cnt + {2'b0, push} - {2'b0, pop};

    // Next-state logic; DRAIN looks at next-cycle occupancy so done follows
    // the last write directly.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_INIT;
            S_INIT:  state_n = S_RUN;
            S_RUN:   if (rd_issue && rd_addr == LAST_ADDR) state_n = S_DRAIN;
            S_DRAIN: if (!vld_pipe[1] && fifo_cnt_n == 3'd0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (kill) state_n = S_IDLE;
    end

    // State, counters, read pipeline and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            vld_pipe <= '0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            state    <= state_n;
            vld_pipe <= kill ? 2'b00 : {vld_pipe[1], rd_issue};
            if (state == S_INIT) begin
                rd_addr  <= '0;
                wr_addr  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (rd_issue) rd_addr <= rd_addr + 1'b1;
                if (pop) begin
                    wr_addr <= wr_addr + 1'b1;
                    rd_ptr  <= rd_ptr + 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                fifo_cnt <= fifo_cnt_n;
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr] <= bus.flt_out;
        end
    end

    assign bus.src_rd_en   = rd_issue;
    assign bus.src_rd_addr = rd_addr;
    assign bus.flt_rst     = !rst_n || (state == S_INIT);
    assign bus.flt_valid   = vld_pipe[1];
    assign bus.flt_pixel   = vld_pipe[1] ? bus.src_rd_data : 8'd0;
    assign bus.dst_wr_en   = pop;
    assign bus.dst_wr_addr = wr_addr;
    assign bus.dst_wr_data = fifo_mem[rd_ptr];
    assign busy            = (state == S_INIT) || in_flow;
    assign done            = (state == S_DONE);
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: source memory and streaming Sobel filter models,
// golden frame results queued per start, a negedge monitor that compares writes.
module tb_sobel_frame_ctrl;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int AW   = 16;
    localparam int NPIX = W * H;
    localparam int IW   = $clog2(NPIX);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy, done;

    sobel_frame_ctrl_if #(.ADDR_W(AW)) bus ();

    sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;

    int   errors = 0, checks = 0;
    int   cyc = 0, t0 = 0;
    int   rdy_mode = 0, stall_lo = 10, stall_hi = 30;
    int   n_rd, first_rd, last_rd, n_frst, frst_rel, n_done, fifo_m;
    wr_t  exp_q[$];
    logic [7:0] src_mem [NPIX];
    logic [7:0] fbuf [NPIX];
    int   fcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // |Gx| + |Gy| over a 3x3 window p[row*3+col], saturated to 8 bits.
    function automatic logic [7:0] sobel(input int p[9]);
        int gx, gy, m;
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'd255 : 8'(m);
    endfunction

    // Filter model window: idx is the newest pixel (bottom-right corner).
    function automatic logic [7:0] filt_at(input int idx, input logic [7:0] newpix);
        int p[9];
        int a;
        for (int k = 0; k < 9; k++) begin
            a    = idx - (2 - k/3)*W - (2 - k%3);
            p[k] = (k == 8) ? int'(newpix) : int'(fbuf[IW'(a)]);
        end
        return sobel(p);
    endfunction

    // Source memory: data the cycle after the read strobe.
    always @(posedge clk)
        if (bus.src_rd_en) bus.src_rd_data <= src_mem[IW'(bus.src_rd_addr)];

    // Streaming filter: one result per interior window, valid held otherwise.
    always @(posedge clk) begin
        if (bus.flt_rst) begin
            fcnt              <= 0;
            bus.flt_out       <= 8'd0;
            bus.flt_out_valid <= 1'b0;
        end else if (bus.flt_valid && fcnt < NPIX) begin
            fbuf[IW'(fcnt)] <= bus.flt_pixel;
            fcnt            <= fcnt + 1;
            if (fcnt / W >= 2 && fcnt % W >= 2) begin
                bus.flt_out       <= filt_at(fcnt, bus.flt_pixel);
                bus.flt_out_valid <= 1'b1;
            end else begin
                bus.flt_out_valid <= 1'b0;
            end
        end
    end

    // Destination back-pressure pattern.
    initial begin
        bus.dst_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       bus.dst_ready = !((cyc - t0) >= stall_lo && (cyc - t0) <= stall_hi);
                2:       bus.dst_ready = 1'($urandom_range(0, 1));
                default: bus.dst_ready = 1'b1;
            endcase
        end
    end

    // Monitor: read ordering, issue rule, FIFO bound and scoreboard compare.
    initial begin
        int   rel, occ;
        logic fv_prev, iss1, iss2, push_now;
        wr_t  e;
        fv_prev = 1'b0; iss1 = 1'b0; iss2 = 1'b0;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (!rst_n) begin
                fifo_m = 0; fv_prev = 1'b0; iss1 = 1'b0; iss2 = 1'b0;
            end else begin
                occ = fifo_m + int'(iss1) + int'(iss2);
                if (bus.src_rd_en) begin
                    if (n_rd == 0) first_rd = rel;
                    last_rd = rel;
                    chk("rd_addr", int'(bus.src_rd_addr), n_rd);
                    chk("issue_rule_occ_lt4", int'(occ < 4), 1);
                    n_rd++;
                end
                if (bus.flt_rst) begin n_frst++; frst_rel = rel; end
                if (done) n_done++;
                if (bus.dst_wr_en) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: addr %0d data %0d, none expected (cycle %0d)",
                                 bus.dst_wr_addr, bus.dst_wr_data, rel);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", int'(bus.dst_wr_addr), int'(e.addr));
                        chk("wr_data", int'(bus.dst_wr_data), int'(e.data));
                    end
                end
                push_now = fv_prev && bus.flt_out_valid;
                if (!busy || bus.flt_rst) fifo_m = 0;
                else begin
                    fifo_m = fifo_m + int'(push_now) - int'(bus.dst_wr_en);
                    if (push_now) chk("fifo_le4", int'(fifo_m <= 4), 1);
                end
                iss2 = iss1; iss1 = bus.src_rd_en; fv_prev = bus.flt_valid;
            end
        end
    end

    task automatic clr_stats();
        n_rd = 0; first_rd = -1; last_rd = -1; n_frst = 0; frst_rel = -1; n_done = 0;
    endtask

    task automatic fill(input bit ramp);
        for (int a = 0; a < NPIX; a++) src_mem[a] = ramp ? 8'(a) : 8'($urandom_range(0, 255));
    endtask

    // Golden results straight from the source frame, raster order.
    task automatic push_expected();
        int p[9];
        int n;
        n = 0;
        for (int r = 1; r < H-1; r++)
            for (int c = 1; c < W-1; c++) begin
                for (int k = 0; k < 9; k++)
                    p[k] = int'(src_mem[IW'((r - 1 + k/3)*W + (c - 1 + k%3))]);
                exp_q.push_back('{addr: AW'(n), data: sobel(p)});
                n++;
            end
    endtask

    task automatic do_start(input int mode);
        rdy_mode = mode;
        clr_stats();
        push_expected();
        @(posedge clk); #1;
        start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full frame; exp_done / exp_last < 0 skip the timing comparisons.
    task automatic run_frame(input int mode, input int exp_done, input int exp_last);
        bit got;
        got = 1'b0;
        do_start(mode);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_seen", int'(got), 1);
        if (exp_done >= 0) chk("done_cycle", cyc - t0, exp_done);
        if (exp_last >= 0) chk("last_rd_cycle", last_rd, exp_last);
        chk("busy_in_done", int'(busy), 0);
        chk("first_rd_cycle", first_rd, 2);
        chk("n_reads", n_rd, NPIX);
        chk("flt_rst_cycles", n_frst, 1);
        chk("flt_rst_at", frst_rel, 1);
        chk("writes_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic abort_frame(input int at, input int mode);
        do_start(mode);
        repeat (at - 1) @(posedge clk);
        #1;
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_rd_en", int'(bus.src_rd_en), 0);
        chk("abort_wr_en", int'(bus.dst_wr_en), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", int'(busy), 0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_src_rd_en", int'(bus.src_rd_en), 0);
        chk("rst_src_rd_addr", int'(bus.src_rd_addr), 0);
        chk("rst_flt_valid", int'(bus.flt_valid), 0);
        chk("rst_flt_pixel", int'(bus.flt_pixel), 0);
        chk("rst_dst_wr_en", int'(bus.dst_wr_en), 0);
        chk("rst_dst_wr_addr", int'(bus.dst_wr_addr), 0);
        chk("rst_dst_wr_data", int'(bus.dst_wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flt_rst", int'(bus.flt_rst), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_flt_rst", int'(bus.flt_rst), 0);
        chk("post_rst_busy", int'(busy), 0);

        fill(1'b1);
        run_frame(0, 53, 49);          // ramp, no back-pressure
        run_frame(1, 61, 57);          // ready low in cycles 10..30
        run_frame(0, 53, 49);          // back-to-back, same frame

        fill(1'b0);
        abort_frame(20, 0);
        run_frame(0, 53, 49);          // clean frame after abort
        fill(1'b1);
        abort_frame(33, 0);            // abort while writes are flowing
        for (int f = 0; f < 4; f++) begin
            fill(1'b0);
            run_frame(2, -1, -1);      // random back-pressure
        end

        // start while running is ignored, then a mid-frame reset
        fill(1'b1);
        do_start(0);
        repeat (7) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("start_ignored_no_init", int'(bus.flt_rst), 0);
        chk("start_ignored_busy", int'(busy), 1);
        repeat (5) @(posedge clk);
        #1; rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_flt_rst", int'(bus.flt_rst), 1);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_busy", int'(busy), 0);
        run_frame(0, 53, 49);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
